// File: rtl/div_seq_4bit_if.sv
// Request/response bundle for the sequential restoring divider.
// Handshake: the requester raises start with A/B valid; the divider takes them
// on the first rising edge where it is idle and ignores start otherwise.
// Results are valid in the single cycle where done is high and stay stable
// until the next accepted start.
interface div_seq_4bit_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [1:0]       state_dbg;

    // Requester side
    modport master (
        output start, A, B,
        input  Quotient, Remainder, busy, done, div_by_zero, state_dbg
    );

    // Divider side
    modport slave (
        input  start, A, B,
        output Quotient, Remainder, busy, done, div_by_zero, state_dbg
    );
endinterface

// File: rtl/div_seq_4bit.sv
// Sequential unsigned restoring divider: one shift and one trial subtraction
// per clock, WIDTH iterations per division. Divide by zero skips the
// iterations and reports all-ones quotient with the dividend as remainder.
module div_seq_4bit #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    div_seq_4bit_if.slave      bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] dvd_q;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dsr_q;      // latched divisor
    logic [WIDTH-1:0] quo_out;
    logic [WIDTH-1:0] rem_out;
    logic             dbz_q;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;

    assign accept    = (state == IDLE) && bus.start;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // One restoring step: the partial remainder stays below the divisor, so the
    // shifted value minus the divisor fits in WIDTH+1 bits and its top bit is
    // the sign that selects restore.
    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dsr_q};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_next = {dvd_q[WIDTH-2:0], q_bit};
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: zero divisor bypasses RUN, DONE always lasts one cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = (bus.B != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, publish on the last step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_out <= '0;
            rem_out <= '0;
            dbz_q   <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            rem_q <= '0;
            dvd_q <= bus.A;
            dsr_q <= bus.B;
            dbz_q <= (bus.B == '0);
            if (bus.B == '0) begin
                quo_out <= '1;
                rem_out <= bus.A;
            end
        end else if (state == RUN) begin
            rem_q <= rem_next;
            dvd_q <= dvd_next;
            cnt   <= cnt + CW'(1);
            if (last_iter) begin
                quo_out <= dvd_next;
                rem_out <= rem_next;
            end
        end
    end

    assign bus.Quotient    = quo_out;
    assign bus.Remainder   = rem_out;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.state_dbg   = state;
endmodule

// File: doc/div_seq_4bit.md
DIV_SEQ_4BIT -- requirements
Module: div_seq_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, sets the operand and result width in bits. All widths below scale with it.
REQ-002 Port: clk  input  1  single rising-edge clock for the whole block.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request a division; sampled on the rising edge of clk.
REQ-005 Port: A  input  WIDTH  unsigned dividend.
REQ-006 Port: B  input  WIDTH  unsigned divisor.
REQ-007 Port: Quotient  output  WIDTH  unsigned quotient, registered.
REQ-008 Port: Remainder  output  WIDTH  unsigned remainder, registered.
REQ-009 Port: busy  output  1  high while a division is iterating.
REQ-010 Port: done  output  1  one-cycle pulse marking Quotient/Remainder valid.
REQ-011 Port: div_by_zero  output  1  high with done when B was zero at start; held until the next accepted start.

Function
REQ-012 The algorithm SHALL be restoring division: one shift plus one trial subtraction per cycle.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 Start acceptance: in IDLE with start=1 at an edge (edge N), latch A and B, clear the iteration counter and clear div_by_zero.
REQ-015 Transition out of IDLE: if B≠0 the state SHALL go to RUN; if B=0 it SHALL go directly to DONE.
REQ-016 start SHALL be ignored in RUN and DONE. Operand changes after edge N SHALL have no effect on the current division.
REQ-017 Each RUN edge SHALL do the following:
 - shift the {partial remainder, dividend} register pair left by 1;
 - compute the trial value partial remainder minus divisor, using WIDTH+1 bits;
 - if the trial is non-negative, keep the trial as the new partial remainder and shift in quotient bit 1;
 - otherwise, keep the old partial remainder and shift in quotient bit 0.
REQ-018 The RUN count SHALL be exactly WIDTH edges (N+1 … N+WIDTH).
REQ-019 At edge N+WIDTH the block SHALL load Quotient and Remainder and enter DONE.
REQ-020 done SHALL be high for exactly the one cycle following edge N+WIDTH.
REQ-021 Total latency from the start edge to done SHALL be WIDTH cycles; the block then returns to IDLE at edge N+WIDTH+1.
REQ-022 busy SHALL be 1 only in RUN, 0 in IDLE and DONE.
REQ-023 Divide by zero: DONE is entered at edge N, and done SHALL pulse the next cycle with:
 - div_by_zero=1;
 - Quotient all ones;
 - Remainder=A.
REQ-024 Result hold: Quotient, Remainder and div_by_zero SHALL hold their values from DONE until the next accepted start. Intermediate RUN values SHALL NOT appear on Quotient or Remainder.
REQ-025 Back-to-back operation: start high in the DONE cycle is ignored; the earliest next acceptance is the first IDLE cycle. start held high continuously SHALL therefore restart every WIDTH+2 cycles.
REQ-026 Results SHALL satisfy A = Quotient*B + Remainder and Remainder < B for every B≠0, including A=0 and A<B.
REQ-027 Internal subtraction SHALL use a WIDTH+1 bit datapath with no overflow; the trial sign bit SHALL select restore.

Reset
REQ-028 While reset_n=0, regardless of clk, the following SHALL hold:
 - state=IDLE;
 - counter=0;
 - Quotient=0 and Remainder=0;
 - busy=0, done=0 and div_by_zero=0.
REQ-029 Reset asserted mid-RUN SHALL abort the division with no done pulse. After reset_n rises, the first start SHALL be accepted normally.
REQ-030 Reset deassertion SHALL take effect on the first clk edge after reset_n rises; no start is sampled while reset_n=0.

Verification
REQ-031 A=13, B=3, start pulse → busy for 4 cycles, then done pulse with Quotient=4, Remainder=1, div_by_zero=0.
REQ-032 A=15, B=1 → Quotient=15, Remainder=0. A=2, B=7 → Quotient=0, Remainder=2. A=0, B=5 → Quotient=0, Remainder=0.
REQ-033 A=5, B=0 → done one cycle after start, busy never high, div_by_zero=1, Quotient=15, Remainder=5.
REQ-034 Start 9/2, then pulse start with 14/3 during RUN and during DONE → both ignored; result Quotient=4, Remainder=1. A new start in IDLE with 14/3 → Quotient=4, Remainder=2.
REQ-035 Start 12/5, then assert reset_n=0 at RUN cycle 2 → all outputs 0 immediately, no done. After release, 12/5 → Quotient=2, Remainder=2.
REQ-036 Exhaustive loop over all 256 A/B pairs, checked against a reference model. Each pair: latency exactly 4 cycles (B≠0) or 1 cycle (B=0), and done width exactly 1 cycle.
